// File: rtl/wb_regfile.sv
// Writeback select and 32 x 8 architectural register file with write-first read bypass,
// plus a committed-write counter and last-destination record for retire accounting.
module wb_regfile #(
    parameter int NREGS = 32,
    parameter int DW    = 8,
    parameter int CW    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               WB,
    input  logic [DW-1:0]            mem_out,
    input  logic [DW-1:0]            ALUOut,
    input  logic [$clog2(NREGS)-1:0] rd,
    input  logic [$clog2(NREGS)-1:0] rs_addr,
    input  logic [$clog2(NREGS)-1:0] rt_addr,
    output logic [DW-1:0]            rs_data,
    output logic [DW-1:0]            rt_data,
    output logic [DW-1:0]            wb_data,
    output logic                     wb_we,
    output logic [CW-1:0]            wr_count,
    output logic [$clog2(NREGS)-1:0] last_rd,
    output logic [DW-1:0]            last_data
);

    localparam int AW = $clog2(NREGS);

    logic [DW-1:0] regFile_q [NREGS];
    logic [CW-1:0] wrCount_q, wrCount_d;
    logic [AW-1:0] lastRd_q;
    logic [DW-1:0] lastData_q;

    logic regWrite;
    logic memToReg;

    assign regWrite = WB[0];
    assign memToReg = WB[1];

    assign wb_data   = memToReg ? mem_out : ALUOut;
    assign wb_we     = regWrite && (rd != '0);
    assign wrCount_d = wrCount_q + CW'(1);

    assign wr_count  = wrCount_q;
    assign last_rd   = lastRd_q;
    assign last_data = lastData_q;

    // r0 always reads zero; an in-flight write to the same index is forwarded before storage
    always_comb begin
        rs_data = regFile_q[rs_addr];
        if (rs_addr == '0) begin
            rs_data = '0;
        end else if (wb_we && (rs_addr == rd)) begin
            rs_data = wb_data;
        end
    end

    always_comb begin
        rt_data = regFile_q[rt_addr];
        if (rt_addr == '0) begin
            rt_data = '0;
        end else if (wb_we && (rt_addr == rd)) begin
            rt_data = wb_data;
        end
    end

    // Reset wins over any write presented in the same cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regFile_q[i] <= '0;
            end
            wrCount_q  <= '0;
            lastRd_q   <= '0;
            lastData_q <= '0;
        end else if (wb_we) begin
            regFile_q[rd] <= wb_data;
            wrCount_q     <= wrCount_d;
            lastRd_q      <= rd;
            lastData_q    <= wb_data;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset, writeback mux, bypass, r0 handling,
// counter wrap and mid-stream reset, each step checked against hand-computed values.
module tb_wb_regfile;

    logic        clk;
    logic        rst_n;
    logic [1:0]  WB;
    logic [7:0]  mem_out;
    logic [7:0]  ALUOut;
    logic [4:0]  rd;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [7:0]  rs_data;
    logic [7:0]  rt_data;
    logic [7:0]  wb_data;
    logic        wb_we;
    logic [15:0] wr_count;
    logic [4:0]  last_rd;
    logic [7:0]  last_data;

    int nChecks = 0;
    int nPass   = 0;

    wb_regfile dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .WB        (WB),
        .mem_out   (mem_out),
        .ALUOut    (ALUOut),
        .rd        (rd),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .wb_data   (wb_data),
        .wb_we     (wb_we),
        .wr_count  (wr_count),
        .last_rd   (last_rd),
        .last_data (last_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change on the falling edge and settle 1 time unit before checks
    task automatic applyStimulus(input logic rst, input logic [1:0] wb, input logic [7:0] mem,
                                 input logic [7:0] alu, input logic [4:0] dst,
                                 input logic [4:0] rsA, input logic [4:0] rtA);
        rst_n   = rst;
        WB      = wb;
        mem_out = mem;
        ALUOut  = alu;
        rd      = dst;
        rs_addr = rsA;
        rt_addr = rtA;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    initial begin
        // Reset held for two edges while a write to r5 is presented
        @(negedge clk);
        applyStimulus(1'b0, 2'b01, 8'h00, 8'h3C, 5'd5, 5'd5, 5'd0);
        tick();
        tick();
        checkOutput("reset_wr_count", 32'(wr_count), 32'h0);
        checkOutput("reset_last_rd", 32'(last_rd), 32'h0);
        checkOutput("reset_last_data", 32'(last_data), 32'h0);
        applyStimulus(1'b1, 2'b00, 8'h00, 8'h3C, 5'd5, 5'd5, 5'd31);
        checkOutput("reset_r5", 32'(rs_data), 32'h0);
        checkOutput("reset_r31", 32'(rt_data), 32'h0);
        applyStimulus(1'b1, 2'b00, 8'h00, 8'h00, 5'd0, 5'd7, 5'd9);
        checkOutput("reset_r7", 32'(rs_data), 32'h0);
        checkOutput("reset_r9", 32'(rt_data), 32'h0);

        // Memory-sourced writeback to r7, then ALU-sourced overwrite
        applyStimulus(1'b1, 2'b11, 8'hA5, 8'h11, 5'd7, 5'd7, 5'd0);
        checkOutput("mux_mem_wb_data", 32'(wb_data), 32'hA5);
        checkOutput("mux_mem_wb_we", 32'(wb_we), 32'h1);
        checkOutput("mux_mem_bypass", 32'(rs_data), 32'hA5);
        tick();
        applyStimulus(1'b1, 2'b01, 8'hA5, 8'h11, 5'd7, 5'd7, 5'd0);
        checkOutput("commit1_wr_count", 32'(wr_count), 32'h1);
        checkOutput("commit1_last_rd", 32'(last_rd), 32'h7);
        checkOutput("commit1_last_data", 32'(last_data), 32'hA5);
        checkOutput("mux_alu_wb_data", 32'(wb_data), 32'h11);
        checkOutput("mux_alu_bypass", 32'(rs_data), 32'h11);
        tick();
        applyStimulus(1'b1, 2'b00, 8'h00, 8'h00, 5'd7, 5'd7, 5'd7);
        checkOutput("commit2_r7", 32'(rs_data), 32'h11);
        checkOutput("commit2_wr_count", 32'(wr_count), 32'h2);
        checkOutput("commit2_last_data", 32'(last_data), 32'h11);

        // Same-cycle bypass on both ports, then storage read
        applyStimulus(1'b1, 2'b01, 8'h00, 8'h5E, 5'd9, 5'd9, 5'd9);
        checkOutput("bypass_rs", 32'(rs_data), 32'h5E);
        checkOutput("bypass_rt", 32'(rt_data), 32'h5E);
        checkOutput("bypass_wr_count", 32'(wr_count), 32'h2);
        tick();
        applyStimulus(1'b1, 2'b00, 8'h00, 8'h5E, 5'd9, 5'd9, 5'd9);
        checkOutput("stored_rs_r9", 32'(rs_data), 32'h5E);
        checkOutput("stored_rt_r9", 32'(rt_data), 32'h5E);
        checkOutput("stored_wr_count", 32'(wr_count), 32'h3);
        checkOutput("stored_last_rd", 32'(last_rd), 32'h9);

        // Write to r0 is discarded; RegWrite=0 still drives wb_data
        applyStimulus(1'b1, 2'b01, 8'h00, 8'hFF, 5'd0, 5'd0, 5'd0);
        checkOutput("r0_wb_we", 32'(wb_we), 32'h0);
        checkOutput("r0_wb_data", 32'(wb_data), 32'hFF);
        checkOutput("r0_read", 32'(rs_data), 32'h0);
        tick();
        applyStimulus(1'b1, 2'b10, 8'h77, 8'h00, 5'd3, 5'd3, 5'd0);
        checkOutput("r0_wr_count", 32'(wr_count), 32'h3);
        checkOutput("nowrite_wb_we", 32'(wb_we), 32'h0);
        checkOutput("nowrite_wb_data", 32'(wb_data), 32'h77);
        checkOutput("nowrite_no_bypass", 32'(rs_data), 32'h0);
        tick();
        applyStimulus(1'b1, 2'b00, 8'h00, 8'h00, 5'd0, 5'd3, 5'd7);
        checkOutput("nowrite_r3", 32'(rs_data), 32'h0);
        checkOutput("nowrite_wr_count", 32'(wr_count), 32'h3);
        checkOutput("nowrite_last_rd", 32'(last_rd), 32'h9);
        checkOutput("dual_read_r7", 32'(rt_data), 32'h11);

        // Counter wrap: clear, then 65536 writes to r1 with data (i+1) mod 256
        applyStimulus(1'b0, 2'b00, 8'h00, 8'h00, 5'd0, 5'd0, 5'd0);
        tick();
        for (int i = 0; i < 65536; i++) begin
            applyStimulus(1'b1, 2'b01, 8'h00, 8'(i + 1), 5'd1, 5'd0, 5'd0);
            if (i == 255) checkOutput("wrap_count_255", 32'(wr_count), 32'd255);
            if (i == 65535) checkOutput("wrap_count_ffff", 32'(wr_count), 32'hFFFF);
            tick();
        end
        applyStimulus(1'b1, 2'b00, 8'h00, 8'h00, 5'd0, 5'd1, 5'd9);
        checkOutput("wrap_wr_count", 32'(wr_count), 32'h0);
        checkOutput("wrap_last_rd", 32'(last_rd), 32'h1);
        checkOutput("wrap_last_data", 32'(last_data), 32'h0);
        checkOutput("wrap_r1", 32'(rs_data), 32'h0);
        checkOutput("wrap_r9_cleared", 32'(rt_data), 32'h0);

        // Mid-stream reset drops the presented write and all prior commits
        applyStimulus(1'b1, 2'b01, 8'h00, 8'h22, 5'd4, 5'd0, 5'd0);
        tick();
        applyStimulus(1'b1, 2'b01, 8'h00, 8'h33, 5'd6, 5'd4, 5'd6);
        checkOutput("pre_reset_r4", 32'(rs_data), 32'h22);
        checkOutput("pre_reset_r6_bypass", 32'(rt_data), 32'h33);
        tick();
        applyStimulus(1'b0, 2'b01, 8'h00, 8'h99, 5'd4, 5'd6, 5'd6);
        checkOutput("pre_reset_wr_count", 32'(wr_count), 32'h2);
        checkOutput("pre_reset_r6", 32'(rs_data), 32'h33);
        tick();
        applyStimulus(1'b1, 2'b00, 8'h00, 8'h00, 5'd0, 5'd4, 5'd6);
        checkOutput("midreset_r4", 32'(rs_data), 32'h0);
        checkOutput("midreset_r6", 32'(rt_data), 32'h0);
        checkOutput("midreset_wr_count", 32'(wr_count), 32'h0);
        checkOutput("midreset_last_rd", 32'(last_rd), 32'h0);
        checkOutput("midreset_last_data", 32'(last_data), 32'h0);
        applyStimulus(1'b1, 2'b01, 8'h00, 8'h44, 5'd4, 5'd0, 5'd0);
        tick();
        applyStimulus(1'b1, 2'b00, 8'h00, 8'h00, 5'd0, 5'd4, 5'd6);
        checkOutput("post_reset_wr_count", 32'(wr_count), 32'h1);
        checkOutput("post_reset_r4", 32'(rs_data), 32'h44);
        checkOutput("post_reset_last_rd", 32'(last_rd), 32'h4);
        checkOutput("post_reset_last_data", 32'(last_data), 32'h44);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
